// File: rtl/dendrite_tm_if.sv
// rtl/dendrite_tm_if.sv - update handshake and compartment data bus for dendrite_tm
interface dendrite_tm_if #(
  parameter int WIDTH   = 16,
  parameter int NUM_SYN = 4
);
  logic                     step;
  logic                     busy;
  logic                     done;
  logic                     sat;
  logic [NUM_SYN*WIDTH-1:0] syn_current;
  logic [WIDTH-1:0]         upper_current;
  logic [WIDTH-1:0]         lower_vmem;
  logic [WIDTH-1:0]         vmem;
  logic [WIDTH-1:0]         lower_current;

  modport master (
    output step, syn_current, upper_current, lower_vmem,
    input  busy, done, sat, vmem, lower_current
  );

  modport slave (
    input  step, syn_current, upper_current, lower_vmem,
    output busy, done, sat, vmem, lower_current
  );
endinterface

// File: rtl/dendrite_tm.sv
// rtl/dendrite_tm.sv - time-multiplexed saturating leaky dendrite compartment
module dendrite_tm #(
  parameter int WIDTH       = 16,
  parameter int NUM_SYN     = 4,
  parameter int SHIFT_DECAY = 15,
  parameter int SHIFT_LOWER = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_en,
  input  logic [WIDTH-1:0] cfg_din,
  output logic [WIDTH-1:0] cfg_dout,
  dendrite_tm_if.slave     bus
);
  localparam int ACC_W = WIDTH + $clog2(NUM_SYN) + 3;
  localparam int PW    = 2*WIDTH + 2;
  localparam int SW    = (ACC_W > PW) ? ACC_W : PW;
  localparam int IDX_W = (NUM_SYN > 1) ? $clog2(NUM_SYN) : 1;
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_SYN-1);

  typedef enum logic [1:0] {IDLE, ACCUM, DECAY, COMMIT} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0]        e_l, tau_mem, g_int;
  logic signed [ACC_W-1:0] acc;
  logic [WIDTH-1:0]        lv;
  logic [IDX_W-1:0]        idx;
  logic [WIDTH-1:0]        vmem_q, lower_q;
  logic                    done_q, sat_q;

  logic signed [WIDTH-1:0] syn_sel;
  logic signed [WIDTH:0]   leak_diff, cpl_diff;
  logic signed [PW-1:0]    leak_prod, cpl_prod, leak_term, cpl_term;
  logic [WIDTH:0]          vmem_sat, lower_sat;

  // Returns {clamped, value} for a wide signed input.
  function automatic logic [WIDTH:0] sat_w(input logic signed [SW-1:0] x);
    if (x > SAT_MAX)      sat_w = {1'b1, SAT_MAX[WIDTH-1:0]};
    else if (x < SAT_MIN) sat_w = {1'b1, SAT_MIN[WIDTH-1:0]};
    else                  sat_w = {1'b0, x[WIDTH-1:0]};
  endfunction

  assign syn_sel   = bus.syn_current[idx*WIDTH +: WIDTH];

  // tau_mem and g_int are unsigned gains, hence the zero extension.
  assign leak_diff = $signed({e_l[WIDTH-1], e_l}) - $signed({vmem_q[WIDTH-1], vmem_q});
  assign leak_prod = PW'(leak_diff) * PW'($signed({1'b0, tau_mem}));
  assign leak_term = leak_prod >>> SHIFT_DECAY;

  assign cpl_diff  = $signed({vmem_q[WIDTH-1], vmem_q}) - $signed({lv[WIDTH-1], lv});
  assign cpl_prod  = PW'(cpl_diff) * PW'($signed({1'b0, g_int}));
  assign cpl_term  = cpl_prod >>> SHIFT_LOWER;

  assign vmem_sat  = sat_w(SW'(acc));
  assign lower_sat = sat_w(SW'(cpl_term));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.step) state_nx = ACCUM;
      ACCUM:   if (idx == IDX_LAST) state_nx = DECAY;
      DECAY:   state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_l      <= '0;
      tau_mem  <= '0;
      g_int    <= '0;
      cfg_dout <= '0;
      acc      <= '0;
      lv       <= '0;
      idx      <= '0;
      vmem_q   <= '0;
      lower_q  <= '0;
      done_q   <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // The chain freezes during an update so gains stay coherent.
      if (cfg_en && state == IDLE) begin
        e_l      <= cfg_din;
        tau_mem  <= e_l;
        g_int    <= tau_mem;
        cfg_dout <= g_int;
      end
      case (state)
        IDLE: begin
          if (bus.step) begin
            acc <= ACC_W'($signed(vmem_q)) + ACC_W'($signed(bus.upper_current));
            lv  <= bus.lower_vmem;
            idx <= '0;
          end
        end
        ACCUM: begin
          acc <= acc + ACC_W'(syn_sel);
          idx <= idx + IDX_W'(1);
        end
        DECAY: acc <= ACC_W'(SW'(acc) + SW'(leak_term));
        COMMIT: begin
          vmem_q  <= vmem_sat[WIDTH-1:0];
          lower_q <= lower_sat[WIDTH-1:0];
          sat_q   <= vmem_sat[WIDTH] | lower_sat[WIDTH];
          done_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy          = (state != IDLE);
  assign bus.done          = done_q;
  assign bus.sat           = sat_q;
  assign bus.vmem          = vmem_q;
  assign bus.lower_current = lower_q;
endmodule

// File: tb/tb_dendrite_tm.sv
// tb/tb_dendrite_tm.sv - vector table and scoreboard bench for dendrite_tm
module tb_dendrite_tm;
  localparam int W = 16;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_en = 1'b0;
  logic [W-1:0] cfg_din = '0;
  logic [W-1:0] cfg_dout;

  dendrite_tm_if #(.WIDTH(W), .NUM_SYN(N)) bus();

  dendrite_tm #(.WIDTH(W), .NUM_SYN(N), .SHIFT_DECAY(15), .SHIFT_LOWER(16)) dut (
    .clk(clk), .reset(rst_n), .cfg_en(cfg_en), .cfg_din(cfg_din),
    .cfg_dout(cfg_dout), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N*W-1:0] syn;
    logic [W-1:0]   upper;
    logic [W-1:0]   lv;
    logic [W-1:0]   e_vmem;
    logic [W-1:0]   e_lc;
    logic           e_sat;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] vmem;
    logic [W-1:0] lc;
    logic         sat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t tbl[7];
  vec_t rtbl[2];
  vec_t v;
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic [N*W-1:0] syn, input logic [W-1:0] upper,
                              input logic [W-1:0] lv, input logic [W-1:0] ev,
                              input logic [W-1:0] elc, input logic es);
    vec_t r;
    r.syn = syn; r.upper = upper; r.lv = lv; r.e_vmem = ev; r.e_lc = elc; r.e_sat = es;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: each done pops the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done expected=no_done at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_vmem", {16'h0, bus.vmem}, {16'h0, mon_e.vmem});
        check("sb_lower_current", {16'h0, bus.lower_current}, {16'h0, mon_e.lc});
        check("sb_sat", {31'h0, bus.sat}, {31'h0, mon_e.sat});
      end
    end
  end

  task automatic cfg_shift(input logic [W-1:0] word);
    cfg_en  = 1'b1;
    cfg_din = word;
    @(negedge clk);
    cfg_en  = 1'b0;
  endtask

  task automatic start_update(input vec_t vv);
    exp_t e;
    bus.syn_current   = vv.syn;
    bus.upper_current = vv.upper;
    bus.lower_vmem    = vv.lv;
    bus.step          = 1'b1;
    e.vmem = vv.e_vmem; e.lc = vv.e_lc; e.sat = vv.e_sat;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string name, input int hold, input int cfg_busy);
    bit seen = 1'b0;
    for (int k = 1; k <= 3*N + 10 && !seen; k++) begin
      @(negedge clk);
      bus.step = (k <= hold);
      cfg_en   = (cfg_busy != 0) && (k <= 3);
      cfg_din  = 16'hBEEF;
      if (k == 1) begin
        check({name, "_busy"}, {31'h0, bus.busy}, 32'd1);
        check({name, "_done_pulse"}, {31'h0, bus.done}, 32'd0);
        bus.lower_vmem = ~bus.lower_vmem;
      end
      if (bus.done) begin
        seen = 1'b1;
        check({name, "_latency"}, k, N + 3);
        check({name, "_busy_clear"}, {31'h0, bus.busy}, 32'd0);
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done expected=done", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.step = 1'b0;
    bus.syn_current = '0;
    bus.upper_current = '0;
    bus.lower_vmem = '0;

    tbl[0] = mk({16'h0000, 16'h0007, 16'hFFE2, 16'h0064}, 16'd50, 16'hFC00, 16'd1151, 16'd1024, 1'b0);
    tbl[1] = mk('0, 16'hFB81, 16'd1151, 16'd0, 16'd0, 1'b0);
    tbl[2] = mk({16'h0000, 16'h0007, 16'hFFE2, 16'h0064}, 16'd50, 16'd0, 16'd127, 16'd0, 1'b0);
    tbl[3] = mk({4{16'h7000}}, 16'd0, 16'd0, 16'h7FFF, 16'd63, 1'b1);
    tbl[4] = mk({4{16'h9000}}, 16'h9000, 16'h8000, 16'h8000, 16'h7FFF, 1'b1);
    tbl[5] = mk('0, 16'h7FFF, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b0);
    tbl[6] = mk({16'd4, 16'd3, 16'd2, 16'd1}, 16'd0, 16'hFFFF, 16'd9, 16'd0, 1'b0);
    rtbl[0] = mk({16'h0000, 16'h0007, 16'hFFE2, 16'h0064}, 16'd50, 16'd0, 16'd127, 16'd0, 1'b0);
    rtbl[1] = mk({4{16'h9000}}, 16'd0, 16'd0, 16'h8000, 16'd0, 1'b1);

    repeat (2) @(negedge clk);
    check("rst_vmem", {16'h0, bus.vmem}, 32'd0);
    check("rst_lower_current", {16'h0, bus.lower_current}, 32'd0);
    check("rst_busy", {31'h0, bus.busy}, 32'd0);
    check("rst_done", {31'h0, bus.done}, 32'd0);
    check("rst_sat", {31'h0, bus.sat}, 32'd0);
    check("rst_cfg_dout", {16'h0, cfg_dout}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    cfg_shift(16'h0000);
    cfg_shift(16'h4000);
    cfg_shift(16'h0800);
    cfg_shift(16'h1234);
    check("cfg_dout_w0", {16'h0, cfg_dout}, 32'h0000);
    cfg_shift(16'h0000);
    check("cfg_dout_w1", {16'h0, cfg_dout}, 32'h4000);
    repeat (2) @(negedge clk);
    check("cfg_idle_hold", {16'h0, cfg_dout}, 32'h4000);
    cfg_shift(16'h4000);
    check("cfg_dout_w2", {16'h0, cfg_dout}, 32'h0800);
    cfg_shift(16'h0800);
    check("cfg_dout_w3", {16'h0, cfg_dout}, 32'h1234);

    // Leak with step held and config shifts attempted while busy.
    v = mk('0, 16'd0, 16'd0, 16'd1024, 16'd0, 1'b0);
    start_update(v);
    wait_done("leak", 3, 1);
    check("cfg_busy_hold", {16'h0, cfg_dout}, 32'h1234);
    bus.step = 1'b0;
    @(negedge clk);

    cfg_shift(16'h8000);
    check("cfg_dout_g_old", {16'h0, cfg_dout}, 32'h0000);
    cfg_shift(16'h0000);
    cfg_shift(16'h0000);

    for (int i = 0; i < 7; i++) begin
      start_update(tbl[i]);
      wait_done($sformatf("vec%0d", i), 0, 0);
    end
    bus.step = 1'b0;
    @(negedge clk);

    cfg_shift(16'hFFFF);
    cfg_shift(16'h0000);
    cfg_shift(16'h0000);
    v = mk('0, 16'h7000, 16'h8000, 16'h7009, 16'h7FFF, 1'b1);
    start_update(v);
    wait_done("cpl_clamp", 0, 0);
    bus.step = 1'b0;
    @(negedge clk);

    // Abort an update mid-ACCUM; no done must follow.
    bus.syn_current = {4{16'h1111}};
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_vmem", {16'h0, bus.vmem}, 32'd0);
    check("abort_lower_current", {16'h0, bus.lower_current}, 32'd0);
    check("abort_busy", {31'h0, bus.busy}, 32'd0);
    check("abort_done", {31'h0, bus.done}, 32'd0);
    check("abort_sat", {31'h0, bus.sat}, 32'd0);
    check("abort_cfg_dout", {16'h0, cfg_dout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    for (int i = 0; i < 2; i++) begin
      start_update(rtbl[i]);
      wait_done($sformatf("post_rst%0d", i), 0, 0);
    end
    bus.step = 1'b0;
    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dendrite_tm.md
# dendrite_tm

Parametrised, time-multiplexed successor of the single-compartment dendrite. One leaky membrane compartment sums `NUM_SYN` synaptic currents, one per clock, through a shared accumulator. It also applies the leak toward `E_l`, adds the upper-compartment current, and computes the coupling current into the lower compartment. Unlike the previous generation, all arithmetic saturates instead of wrapping, updates run under a step/done handshake, and the configuration chain runs on the system clock.

## Interface
- `WIDTH`, 16: word length of all currents, voltages and config words; two's complement (TC).
- `NUM_SYN`, 4: number of synapse inputs; must be at least 1.
- `SHIFT_DECAY`, 15: arithmetic right shift applied to the leak product.
- `SHIFT_LOWER`, 16: arithmetic right shift applied to the coupling product.

- `clk` in 1: system clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `cfg_en` in 1: shift enable for the config chain.
- `cfg_din` in WIDTH: config chain input.
- `cfg_dout` out WIDTH: config chain output, for daisy-chaining.
- `step` in 1: start one membrane update.
- `busy` out 1: update in progress.
- `done` out 1: one-cycle pulse when the update commits.
- `sat` out 1: the last committed update clamped `vmem` or `lower_current`.
- `syn_current` in NUM_SYN*WIDTH: TC synapse currents; synapse i is `[i*WIDTH +: WIDTH]`.
- `upper_current` in WIDTH: TC current from the upper compartment.
- `lower_vmem` in WIDTH: TC membrane voltage of the lower compartment.
- `vmem` out WIDTH: TC membrane voltage (register).
- `lower_current` out WIDTH: TC current into the lower compartment (register).

## Operation
- **Config chain** (shifts when `cfg_en`=1 and `busy`=0):
  - `E_l` <= `cfg_din`; `tau_mem` <= `E_l`; `g_int` <= `tau_mem`; `cfg_dout` <= `g_int`.
  - `cfg_en` while `busy`=1 is ignored; the chain holds its values.
- `tau_mem` and `g_int` are unsigned; they are zero-extended to WIDTH+1 before signed multiply.
- **Accumulator** `acc`: signed, WIDTH+clog2(NUM_SYN)+3 bits. All additions are sign-extended into it.
- **States:** IDLE, ACCUM, DECAY, COMMIT.
- **IDLE:** `step`=1 at an edge:
  - `acc` <= `vmem` + `upper_current`.
  - Latch `lower_vmem` into `lv`.
  - `idx` <= 0, `busy` <= 1, clear `sat_int`, go to ACCUM.
- **ACCUM:** each edge, `acc` += `syn_current[idx]` and `idx`++. After `idx`=NUM_SYN-1 is added, go to DECAY.
- **DECAY:** `acc` += (`E_l` − `vmem`) * `tau_mem` >>> `SHIFT_DECAY`.
  - The difference is WIDTH+1 bits; the product is 2*WIDTH+2 bits and is not truncated before the shift.
  - Go to COMMIT.
- **COMMIT:**
  - `vmem` <= sat(`acc`).
  - `lower_current` <= sat((`vmem` − `lv`) * `g_int` >>> `SHIFT_LOWER`), using the pre-commit `vmem`.
  - `sat` <= 1 if either value was clamped, else 0.
  - `done` <= 1, `busy` <= 0, go to IDLE.
- **sat(x):** clamps to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- `vmem` is constant throughout an update; both DECAY and COMMIT use the old value.
- `step` outside IDLE is ignored.
- `syn_current` and `upper_current` must be held stable by the source while `busy`=1. `lower_vmem` is sampled only at the start edge.

## Timing
- Reset (async assert): state IDLE; `vmem`, `lower_current`, `E_l`, `tau_mem`, `g_int`, `cfg_dout` = 0; `busy`, `done`, `sat` = 0.
- Reset mid-update: the update is aborted, no `done` is issued, and all outputs read 0.
- Let E0 be the edge that accepts `step`:
  - `busy` is high from after E0 until after E(NUM_SYN+2).
  - `vmem`, `lower_current` and `sat` update at E(NUM_SYN+2).
  - `done` is high for exactly the cycle after E(NUM_SYN+2).
- Latency is NUM_SYN+2 cycles. A `step` held high in the `done` cycle is accepted, giving a back-to-back period of NUM_SYN+3 cycles.
- Config: a word presented with `cfg_en` appears on `cfg_dout` 4 shifting edges later.

## Test plan
- **Reset:** assert `reset`=0 mid-ACCUM, then release -> all outputs 0, `busy`=0, no `done`, next `step` is accepted normally.
- **Config chain:** shift 0x0000, 0x4000, 0x0800, 0x1234 -> `g_int`=0x4000, `tau_mem`=0x0800, `E_l`=0x1234, `cfg_dout`=0x0000. A shift during `busy` -> registers unchanged.
- **Leak:** `E_l`=2048, `tau_mem`=16384, `vmem`=0, all currents 0, `step` -> `done` 6 cycles after E0, `vmem`=1024, `sat`=0.
- **Synaptic sum:** `tau_mem`=0, syn={100, −30, 7, 0}, `upper_current`=50 -> `vmem`=127. A second `step` issued while `busy` is ignored, giving exactly one `done`.
- **Saturation:** `tau_mem`=0, all syn=0x7000 -> `vmem`=0x7FFF, `sat`=1. All syn=0x9000 from reset -> `vmem`=0x8000, `sat`=1.
- **Coupling:** `g_int`=0x8000, `vmem`=1024, `lower_vmem`=−1024, `tau_mem`=0 -> `lower_current`=1024. Change `lower_vmem` after E0 -> result unchanged.
